traceback_unit: RTL and testbench

//  Viterbi traceback stage between the ACS array and the reverse stack.

---
 rtl/traceback_unit.sv | 92 +++++++++
 tb/tb_traceback_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/traceback_unit.sv
// Viterbi traceback: 3-bank survivor ring (write / train / decode), one traceback step per stage.
// Build option TBU_BEST_STATE_EN adds best_state as the training start; otherwise training starts at state 0.
module traceback_unit #(
  parameter int NUM_STATES = 4,
  parameter int SW         = 2,
  parameter int L          = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [NUM_STATES-1:0] dec_bits,
`ifdef TBU_BEST_STATE_EN
  input  logic [SW-1:0]         best_state,
`endif
  output logic                  decode_out,
  output logic                  stack_toggle,
  output logic                  out_valid
);

  localparam int CW = $clog2(L);

  logic [NUM_STATES-1:0] mem [3][L];

  logic [CW-1:0]         wr_col;
  logic [CW-1:0]         rd_col;
  logic [1:0]            wbank;
  logic [1:0]            tbank;
  logic [1:0]            dbank;
  logic [1:0]            blk_cnt;
  logic [SW-1:0]         train_state;
  logic [SW-1:0]         dec_state;
  logic [SW-1:0]         train_pred;
  logic [SW-1:0]         dec_pred;
  logic [SW-1:0]         start_state;
  logic [NUM_STATES-1:0] tcol;
  logic [NUM_STATES-1:0] dcol;
  logic                  boundary;

  // train bank is the one written last block, decode bank the one before that
  assign tbank    = (wbank == 2'd0) ? 2'd2 : wbank - 2'd1;
  assign dbank    = (wbank == 2'd2) ? 2'd0 : wbank + 2'd1;
  assign rd_col   = CW'(L - 1) - wr_col;
  assign boundary = (wr_col == CW'(L - 1));

  assign tcol       = mem[tbank][rd_col];
  assign dcol       = mem[dbank][rd_col];
  assign train_pred = {tcol[train_state], train_state[SW-1:1]};
  assign dec_pred   = {dcol[dec_state], dec_state[SW-1:1]};

`ifdef TBU_BEST_STATE_EN
  assign start_state = best_state;
`else
  assign start_state = '0;
`endif

  // survivor memory is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (dec_valid && !reset) begin
      mem[wbank][wr_col] <= dec_bits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_col       <= '0;
      wbank        <= '0;
      blk_cnt      <= '0;
      train_state  <= '0;
      dec_state    <= '0;
      decode_out   <= 1'b0;
      stack_toggle <= 1'b0;
      out_valid    <= 1'b0;
    end else if (dec_valid) begin
      decode_out <= dec_state[0];
      out_valid  <= (blk_cnt == 2'd2);
      if (boundary) begin
        wr_col       <= '0;
        wbank        <= (wbank == 2'd2) ? 2'd0 : wbank + 2'd1;
        stack_toggle <= ~stack_toggle;
        // decoding of the next block resumes from where training reached column 0
        dec_state    <= train_pred;
        train_state  <= start_state;
        if (blk_cnt != 2'd2) blk_cnt <= blk_cnt + 2'd1;
      end else begin
        wr_col      <= wr_col + CW'(1);
        train_state <= train_pred;
        dec_state   <= dec_pred;
      end
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: directed stimulus, per-cycle check against a block-level traceback model.
// Honours TBU_BEST_STATE_EN when the design is built with it.
module tb_traceback_unit;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int L  = 21;
`ifdef TBU_BEST_STATE_EN
  localparam bit USE_BEST = 1'b1;
  localparam int EXP_TS   = 2;
`else
  localparam bit USE_BEST = 1'b0;
  localparam int EXP_TS   = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [NS-1:0] dec_bits;
  logic [SW-1:0] best_state;
  logic          decode_out, stack_toggle, out_valid;

  always #5 clk = ~clk;

  traceback_unit #(.NUM_STATES(NS), .SW(SW), .L(L)) dut (
    .clk(clk),
    .reset(reset),
    .dec_valid(dec_valid),
    .dec_bits(dec_bits),
`ifdef TBU_BEST_STATE_EN
    .best_state(best_state),
`endif
    .decode_out(decode_out),
    .stack_toggle(stack_toggle),
    .out_valid(out_valid)
  );

  // model: every stage's decisions and each boundary's best_state since the last reset
  logic [NS-1:0] stg[$];
  logic [SW-1:0] bst[$];
  logic          strm[$];
  logic          q4[$];
  int            nv;
  logic          exp_vld, exp_tog, exp_out;
  bit            out_known, chk_on;
  int            n_cmp = 0, n_bad = 0;
  bit            pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  function automatic logic [SW-1:0] pred(logic [SW-1:0] s, logic [NS-1:0] d);
    return {d[s], s[SW-1:1]};
  endfunction

  // block n decodes block n-2: full training pass over it, then k decode steps from its last column
  function automatic logic model_bit(int n, int k);
    logic [SW-1:0] s;
    int base;
    base = (n - 2) * L;
    s = USE_BEST ? bst[n-2] : '0;
    for (int c = L - 1; c >= 0; c--) s = pred(s, stg[base+c]);
    for (int j = 0; j < k; j++) s = pred(s, stg[base+L-1-j]);
    return s[0];
  endfunction

  function automatic logic [NS-1:0] pat_dec(int t);
    logic u;
    u = (t < 2) ? 1'b0 : pat[(t-2)%4];
    return {NS{u}};
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    stg.delete(); bst.delete(); strm.delete();
    nv = 0; exp_vld = 1'b0; exp_tog = 1'b0; exp_out = 1'b0; out_known = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; dec_valid = 1'b0;
    @(posedge clk); #1;
    clear_model();
    chk_on = 1'b1;
    repeat (cycles - 1) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  task automatic step(input logic v, input logic [NS-1:0] bits);
    dec_valid = v; dec_bits = bits;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    if (v) begin
      stg.push_back(bits);
      nv++;
      if (nv % L == 0) bst.push_back(best_state);
      exp_vld   = (nv > 2 * L);
      exp_tog   = ((nv / L) % 2) == 1;
      out_known = exp_vld;
      if (exp_vld) begin
        exp_out = model_bit((nv - 1) / L, (nv - 1) % L);
        strm.push_back(decode_out);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", out_valid, exp_vld);
      chk("stack_toggle", stack_toggle, exp_tog);
      if (out_known) chk("decode_out", decode_out, exp_out);
    end
  end

  // hand-derived decoded bits for the 1,0,1,1 pattern: {valid number, bit}
  int   lit_v[9]   = '{43, 44, 45, 46, 63, 64, 65, 66, 68};
  logic lit_b[9]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    chk_on = 1'b0; dec_bits = '0; best_state = '0;

    // 1: reset state
    do_reset(2);
    chk("rst_dout", decode_out, 1'b0);
    chk("rst_tog", stack_toggle, 1'b0);
    chk("rst_vld", out_valid, 1'b0);

    // 2: all-zero decisions
    for (int i = 1; i <= 63; i++) begin
      step(1'b1, 4'b0000);
      if (i == 21) chk("t2_tog21", stack_toggle, 1'b1);
      if (i == 42) begin chk("t2_tog42", stack_toggle, 1'b0); chk("t2_vld42", out_valid, 1'b0); end
      if (i == 43) chk("t2_vld43", out_valid, 1'b1);
      if (i == 63) begin chk("t2_tog63", stack_toggle, 1'b1); chk("t2_dout63", decode_out, 1'b0); end
    end

    // 3: all-one decisions
    do_reset(2);
    for (int i = 1; i <= 84; i++) begin
      step(1'b1, 4'b1111);
      if (i > 42) chk("t3_dout", decode_out, 1'b1);
    end

    // 4: noiseless K=3 decisions for 1,0,1,1 repeated
    do_reset(2);
    for (int t = 0; t < 84; t++) begin
      step(1'b1, pat_dec(t));
      for (int j = 0; j < 9; j++)
        if (lit_v[j] == t + 1) chk("t4_lit", decode_out, lit_b[j]);
    end
    chk("model_2_0", model_bit(2, 0), 1'b0);
    chk("model_2_2", model_bit(2, 2), 1'b1);
    chk("model_3_1", model_bit(3, 1), 1'b1);
    chk("model_3_4", model_bit(3, 4), 1'b0);
    q4 = strm;

    // 5: same stream with a 5-cycle stall mid-block
    do_reset(2);
    for (int t = 0; t < 84; t++) begin
      step(1'b1, pat_dec(t));
      if (t == 29) begin
        chk_i("t5_wrcol_pre", int'(dut.wr_col), 9);
        repeat (5) step(1'b0, 4'b1010);
        chk_i("t5_wrcol_post", int'(dut.wr_col), 9);
        chk_i("t5_ts_hold", int'(dut.blk_cnt), 1);
      end
    end
    n_cmp++;
    if (strm != q4) begin
      n_bad++;
      $display("FAIL t5_stream: got %0d bits want %0d bits identical to unstalled run", strm.size(), q4.size());
    end

    // 6: reset mid-block, then refill
    do_reset(2);
    for (int t = 0; t < 30; t++) step(1'b1, pat_dec(t));
    do_reset(1);
    chk("t6_dout", decode_out, 1'b0);
    chk("t6_tog", stack_toggle, 1'b0);
    chk("t6_vld", out_valid, 1'b0);
    best_state = 2'd2;
    for (int t = 0; t < 43; t++) begin
      step(1'b1, pat_dec(t));
      if (t < 42) chk("t6_vld_fill", out_valid, 1'b0);
      if (t == 20) chk_i("t6_train_state", int'(dut.train_state), EXP_TS);
    end
    chk("t6_vld43", out_valid, 1'b1);
    step(1'b0, '0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
